// File: rtl/bram_arbiter_pkg.sv
// Shared definitions for the CPU/video BRAM arbiter: owner encoding and
// default geometry.
package bram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } own_e;

  localparam int DEF_ADDR_W   = 13;
  localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/bram_arbiter.sv
// Two-port arbiter sharing one BRAM between a CPU (priority, stallable) and a
// video read port protected from starvation by a bounded-wait counter.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_cs_n_i,
  input  logic [3:0]        cpu_we_n_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_gnt_o,
  output logic              vid_valid_o,
  output logic [31:0]       vid_data_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_cs_n_o,
  output logic [3:0]        ram_we_n_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  own_e              owner_d;
  own_e              owner_q;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       cpu_hold;
  logic [31:0]       vid_hold;
  logic              cpu_req;
  logic              starved;

  assign cpu_req = ~cpu_cs_n_i;
  assign starved = (wait_cnt >= MAX_WAIT_C);

  // Owner depends only on request inputs and wait_cnt, never on ram_data_i.
  always_comb begin
    owner_d = OWN_NONE;
    if (!rst_i) begin
      if (cpu_req && vid_req_i) owner_d = starved ? OWN_VID : OWN_CPU;
      else if (cpu_req)         owner_d = OWN_CPU;
      else if (vid_req_i)       owner_d = OWN_VID;
    end
  end

  always_comb begin
    ram_addr_o = addr_q;
    ram_cs_n_o = 1'b1;
    ram_we_n_o = 4'hF;
    ram_data_o = cpu_data_i;
    case (owner_d)
      OWN_CPU: begin
        ram_addr_o = cpu_addr_i;
        ram_cs_n_o = 1'b0;
        ram_we_n_o = cpu_we_n_i;
      end
      OWN_VID: begin
        ram_addr_o = vid_addr_i;
        ram_cs_n_o = 1'b0;
      end
      default: ;
    endcase
  end

  assign vid_gnt_o   = (owner_d == OWN_VID);
  assign cpu_stall_o = cpu_req && !rst_i && (owner_d != OWN_CPU);

  // BRAM data arrives one cycle after the access, i.e. while owner_q names the
  // port that issued it; otherwise each port sees its last captured word.
  assign vid_valid_o = (owner_q == OWN_VID);
  assign vid_data_o  = (owner_q == OWN_VID) ? ram_data_i : vid_hold;
  assign cpu_data_o  = (owner_q == OWN_CPU) ? ram_data_i : cpu_hold;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q  <= OWN_NONE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      cpu_hold <= 32'd0;
      vid_hold <= 32'd0;
    end else begin
      owner_q <= owner_d;
      if (vid_gnt_o)                         wait_cnt <= 4'd0;
      else if (vid_req_i && wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
      if (owner_d != OWN_NONE) addr_q <= ram_addr_o;
      if (owner_q == OWN_CPU)  cpu_hold <= ram_data_i;
      if (owner_q == OWN_VID)  vid_hold <= ram_data_i;
    end
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 13, word-address width of the shared BRAM.
- MAX_WAIT, 4, consecutive denied video cycles before video is forced a grant (1..15).

REQ-002 The block SHALL have these ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- cpu_addr_i  in  ADDR_W  CPU word address.
- cpu_cs_n_i  in  1  CPU chip select, active-low.
- cpu_we_n_i  in  4  CPU byte write enables, active-low.
- cpu_data_i  in  32  CPU write data.
- cpu_data_o  out  32  CPU read data.
- cpu_stall_o  out  1  freezes the processor while the CPU is denied.
- vid_req_i  in  1  video read request, held until granted.
- vid_addr_i  in  ADDR_W  video word address.
- vid_gnt_o  out  1  video request accepted this cycle.
- vid_valid_o  out  1  vid_data_o valid, one-cycle pulse.
- vid_data_o  out  32  video read data.
- ram_addr_o  out  ADDR_W  BRAM address.
- ram_cs_n_o  out  1  BRAM select, active-low.
- ram_we_n_o  out  4  BRAM byte write enables, active-low.
- ram_data_o  out  32  BRAM write data.
- ram_data_i  in  32  BRAM read data, valid one cycle after the access.

Function
REQ-003 Each cycle SHALL have exactly one BRAM owner, decided combinationally: NONE, CPU or VID.

REQ-004 Arbitration SHALL follow this table:
- CPU only (cpu_cs_n_i=0, vid_req_i=0) -> CPU.
- Video only -> VID.
- Both, wait_cnt<MAX_WAIT -> CPU.
- Both, wait_cnt>=MAX_WAIT -> VID.
- Neither -> NONE.

REQ-005 wait_cnt SHALL be a 4-bit counter:
- Increments, saturating at 15, when vid_req_i=1 and vid_gnt_o=0.
- Clears to 0 in any cycle with vid_gnt_o=1.
- Holds otherwise.

REQ-006 cpu_stall_o SHALL be 1 exactly when cpu_cs_n_i=0 and the owner is not CPU; it is combinational, with no added cycle.

REQ-007 Owner CPU SHALL drive the BRAM from the CPU port:
- ram_addr_o=cpu_addr_i, ram_we_n_o=cpu_we_n_i, ram_data_o=cpu_data_i, ram_cs_n_o=0.

REQ-008 Owner VID SHALL drive a read only:
- ram_addr_o=vid_addr_i, ram_we_n_o=4'hF, ram_cs_n_o=0, vid_gnt_o=1.

REQ-009 Owner NONE SHALL deselect the BRAM:
- ram_cs_n_o=1, ram_we_n_o=4'hF; ram_addr_o holds its last value.

REQ-010 The state register owner_q SHALL hold the previous cycle's owner, encoded NONE/CPU/VID. It is the block's state machine, with a transition every clock to the newly computed owner.

REQ-011 When owner_q=VID:
- vid_valid_o=1.
- vid_data_o=ram_data_i, registered into a hold register so it stays stable afterwards.
- Read latency is grant + 1 cycle.

REQ-012 When owner_q=CPU:
- cpu_data_o=ram_data_i, also captured into cpu_hold.
- In all other cycles cpu_data_o=cpu_hold, so a stalled CPU sees stable data.

REQ-013 A CPU write grant SHALL still update cpu_hold from ram_data_i on the following cycle; the write-first or read-first behaviour is whatever the BRAM provides.

REQ-014 A video request that changes vid_addr_i before grant is legal; the address sampled in the grant cycle SHALL be used.

REQ-015 A forced video grant SHALL stall the CPU for exactly one cycle. The CPU is then served, because wait_cnt is 0 again.

Reset
REQ-016 Asserting rst_i SHALL asynchronously set:
- owner_q=NONE, wait_cnt=0, cpu_hold=0, vid_data_o hold=0.
- vid_valid_o=0, vid_gnt_o=0 (when vid_req_i=0), cpu_stall_o=0 (when cpu_cs_n_i=1).
- ram_cs_n_o=1, ram_we_n_o=4'hF, ram_addr_o=0.

REQ-017 While rst_i=1, arbitration SHALL be suppressed:
- The owner is forced to NONE.
- vid_gnt_o=0 and cpu_stall_o=0.

REQ-018 Reset during an outstanding read SHALL discard that read: no vid_valid_o pulse after deassertion.

REQ-019 Deassertion SHALL be synchronous to clk_i, through the existing SoC reset synchronizer.

Structure
REQ-020 A shared package SHALL hold:
- the owner encoding (OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_VID=2'd2);
- the ADDR_W and MAX_WAIT defaults.

REQ-021 The block SHALL be a single module with no sub-module. The starvation counter and data-hold registers are inline.

REQ-022 No combinational path SHALL run from ram_data_i to cpu_stall_o or vid_gnt_o.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- CPU-only read at address 0x010, BRAM word 0xDEADBEEF -> cpu_stall_o=0 and cpu_data_o=0xDEADBEEF one cycle later; vid_valid_o=0.
- Video-only read at address 0x020, word 0x12345678 -> vid_gnt_o=1 in cycle N and vid_valid_o=1 with vid_data_o=0x12345678 in cycle N+1.
- CPU and video both continuously requesting, MAX_WAIT=4 -> video denied 4 cycles, granted in the 5th, CPU stalled exactly that cycle; the pattern repeats every 5 cycles.
- CPU write 0xA5A5A5A5 with cpu_we_n_i=4'b1100 while video requests -> ram_we_n_o=4'b1100 in the CPU cycle and 4'hF in every VID cycle; a subsequent video read returns the merged word.
- rst_i asserted in the cycle after a video grant -> no vid_valid_o pulse; after release owner_q=NONE, wait_cnt=0 and cpu_data_o=0.
- Video holding the request for 20 cycles with the CPU idle -> a grant every cycle, wait_cnt stays 0 and vid_valid_o stays continuously high from cycle 2.
